// File: rtl/ahb_console_tx_if.sv
// ============================================================================
// Module      : ahb_console_tx_if
// Description : AHB-Lite slave bus bundle for the console transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ahb_console_tx_if;
  logic        HSEL_I;
  logic        HREADY_I;
  logic        HWRITE_I;
  logic [2:0]  HSIZE_I;
  logic [11:0] HADDR_I;
  logic [31:0] HRDATA_I;
  logic [31:0] HWDATA_O;
  logic        HREADY_O;
  logic        HRESP_O;

  modport slave (
    input  HSEL_I, HREADY_I, HWRITE_I, HSIZE_I, HADDR_I, HRDATA_I,
    output HWDATA_O, HREADY_O, HRESP_O
  );

  modport master (
    output HSEL_I, HREADY_I, HWRITE_I, HSIZE_I, HADDR_I, HRDATA_I,
    input  HWDATA_O, HREADY_O, HRESP_O
  );
endinterface

`default_nettype wire

// File: rtl/ahb_console_tx.sv
// ============================================================================
// Module      : ahb_console_tx
// Description : AHB-Lite console UART transmitter (8N1) with a TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_console_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             HCLK_I,
  input  logic             HRESET_I,
  ahb_console_tx_if.slave  ahb,
  output logic             TXD_O
);

  localparam int              c_aw       = $clog2(FIFO_DEPTH);
  localparam logic [15:0]     c_div_last = 16'(CLK_DIV - 1);
  localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
  localparam logic [c_aw:0]   c_cnt_one  = (c_aw + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [2:0]      r_adr;
  logic            r_wr;
  logic            r_rd;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_aw:0]   r_count;
  logic            r_ovf;
  logic            r_enable;
  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     r_div;
  logic [15:0]     w_div_next;
  logic [2:0]      r_bit;
  logic [2:0]      w_bit_next;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_next;
  logic            r_txd;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_wr_data;
  logic            w_push;
  logic            w_ovf_set;
  logic            w_rd_status;
  logic            w_div_done;
  logic            w_idle;
  logic [6:0]      w_cnt7;
  logic [31:0]     w_status;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_unused = ^{ahb.HSIZE_I, ahb.HADDR_I[11:5], ahb.HADDR_I[1:0], ahb.HRDATA_I[31:8]};

  assign ahb.HREADY_O = 1'b1;
  assign ahb.HRESP_O  = 1'b0;

  always_ff @(posedge HCLK_I or posedge HRESET_I) begin
    if (HRESET_I) begin
      r_adr <= 3'd0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
    end else if (ahb.HSEL_I && ahb.HREADY_I) begin
      r_adr <= ahb.HADDR_I[4:2];
      r_wr  <= ahb.HWRITE_I;
      r_rd  <= !ahb.HWRITE_I;
    end else begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
    end
  end

  // Full is judged on the pre-pop count, so a write racing a pop still drops.
  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  assign w_wr_data   = r_wr && (r_adr == 3'd0);
  assign w_push      = w_wr_data && !w_full;
  assign w_ovf_set   = w_wr_data && w_full;
  assign w_rd_status = r_rd && (r_adr == 3'd1);

  always_ff @(posedge HCLK_I) begin
    if (w_push) r_mem[r_wptr] <= ahb.HRDATA_I[7:0];
  end

  always_ff @(posedge HCLK_I or posedge HRESET_I) begin
    if (HRESET_I) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_enable <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (w_rd_status) r_ovf <= 1'b0;
      if (r_wr && (r_adr == 3'd2)) r_enable <= ahb.HRDATA_I[0];
    end
  end

  assign w_idle   = w_empty && (r_state == S_IDLE);
  assign w_cnt7   = 7'(r_count);
  assign w_status = {17'd0, w_cnt7, 5'd0, r_ovf, w_full, w_idle};

  always_comb begin
    w_rdata = 32'd0;
    if (r_rd) begin
      case (r_adr)
        3'd1:    w_rdata = w_status;
        3'd2:    w_rdata = {31'd0, r_enable};
        default: w_rdata = 32'd0;
      endcase
    end
  end

  assign ahb.HWDATA_O = w_rdata;

  assign w_div_done = (r_div == c_div_last);

  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_enable && !w_empty) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rptr];
          w_div_next   = 16'd0;
        end
      end
      S_START: begin
        if (w_div_done) begin
          w_div_next   = 16'd0;
          w_bit_next   = 3'd0;
          w_state_next = S_DATA;
        end else begin
          w_div_next   = r_div + 16'd1;
        end
      end
      S_DATA: begin
        if (w_div_done) begin
          w_div_next   = 16'd0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_next   = 3'd0;
            w_state_next = S_STOP;
          end else begin
            w_bit_next   = r_bit + 3'd1;
          end
        end else begin
          w_div_next   = r_div + 16'd1;
        end
      end
      S_STOP: begin
        // Chaining straight into START keeps back-to-back frames gap-free.
        if (w_div_done) begin
          w_div_next = 16'd0;
          if (r_enable && !w_empty) begin
            w_state_next = S_START;
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rptr];
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_div_next = r_div + 16'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK_I or posedge HRESET_I) begin
    if (HRESET_I) begin
      r_state <= S_IDLE;
      r_div   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_txd   <= (r_state == S_START) ? 1'b0 :
                 (r_state == S_DATA)  ? r_shift[0] : 1'b1;
    end
  end

  assign TXD_O = r_txd;

endmodule

`default_nettype wire

// File: tb/tb_ahb_console_tx.sv
// ============================================================================
// Module      : tb_ahb_console_tx
// Description : Self-checking bench for ahb_console_tx with a UART line model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_console_tx;
  localparam int          D        = 4;
  localparam int          DEPTH    = 8;
  localparam logic [11:0] A_DATA   = 12'h000;
  localparam logic [11:0] A_STATUS = 12'h004;
  localparam logic [11:0] A_CTRL   = 12'h008;
  localparam logic [11:0] A_SPARE  = 12'h01C;

  logic HCLK_I   = 1'b0;
  logic HRESET_I = 1'b1;
  logic TXD_O;

  ahb_console_tx_if ahb();

  ahb_console_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .HCLK_I   (HCLK_I),
    .HRESET_I (HRESET_I),
    .ahb      (ahb),
    .TXD_O    (TXD_O)
  );

  always #5 HCLK_I = ~HCLK_I;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Line receiver: every bit must hold for exactly D samples.
  int         cyc = 0;
  bit         rx_busy = 0;
  int         rx_t = 0;
  logic [9:0] rx_bits;
  int         frame_err = 0;
  logic [7:0] rx_byte_q[$];
  logic [9:0] rx_frame_q[$];
  int         rx_start_q[$];

  always @(negedge HCLK_I) begin
    cyc++;
    if (HRESET_I) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (TXD_O === 1'b0) begin
        rx_busy = 1;
        rx_t    = 0;
        rx_bits = 10'd0;
        rx_start_q.push_back(cyc);
      end
    end else begin
      rx_t++;
      if (rx_t % D == 0) rx_bits[rx_t / D] = TXD_O;
      else if (TXD_O !== rx_bits[rx_t / D]) frame_err++;
      if (rx_t == 10 * D - 1) begin
        rx_busy = 0;
        if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) frame_err++;
        rx_frame_q.push_back(rx_bits);
        rx_byte_q.push_back(rx_bits[8:1]);
      end
    end
  end

  task automatic bus_cycle(input bit sel, input bit wr, input logic [11:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata);
    rdata        = ahb.HWDATA_O;
    ahb.HSEL_I   = sel;
    ahb.HWRITE_I = wr;
    ahb.HADDR_I  = addr;
    ahb.HRDATA_I = wdata;
    ahb.HSIZE_I  = 3'd2;
    ahb.HREADY_I = 1'b1;
    @(posedge HCLK_I); #1;
  endtask

  task automatic ahb_write(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] r;
    bus_cycle(1'b1, 1'b1, addr, 32'd0, r);
    bus_cycle(1'b0, 1'b0, 12'd0, data, r);
  endtask

  task automatic ahb_read(input logic [11:0] addr, output logic [31:0] data);
    logic [31:0] r;
    bus_cycle(1'b1, 1'b0, addr, 32'd0, r);
    bus_cycle(1'b0, 1'b0, 12'd0, 32'd0, data);
  endtask

  task automatic wait_frames(input int n, input int limit, output bit ok);
    int k = 0;
    while (rx_byte_q.size() < n && k < limit) begin
      @(posedge HCLK_I); #1;
      k++;
    end
    ok = (rx_byte_q.size() >= n);
  endtask

  task automatic clear_rx();
    rx_byte_q.delete();
    rx_frame_q.delete();
    rx_start_q.delete();
    frame_err = 0;
  endtask

  task automatic do_reset();
    HRESET_I = 1'b1;
    ahb.HSEL_I = 1'b0;
    repeat (2) @(posedge HCLK_I);
    #1;
    HRESET_I = 1'b0;
    exp_q.delete();
    clear_rx();
  endtask

  task automatic fill_fifo(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      ahb_write(A_DATA, {24'($urandom), b});
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(posedge HCLK_I);
    #1;
    checks++; if (TXD_O !== 1'b1) begin errors++; $display("FAIL rst_txd: got %b expected 1", TXD_O); end
    checks++; if (ahb.HWDATA_O !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", ahb.HWDATA_O); end
    checks++; if (ahb.HREADY_O !== 1'b1 || ahb.HRESP_O !== 1'b0) begin errors++; $display("FAIL rst_hready_hresp: got %b%b expected 10", ahb.HREADY_O, ahb.HRESP_O); end
    HRESET_I = 1'b0;
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0001) begin errors++; $display("FAIL rst_status: got %h expected 00000001", r); end
    ahb_read(A_CTRL, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h expected 0", r); end
  endtask

  task automatic test_single_frame();
    logic [31:0] r;
    int c0;
    bit ok;
    ahb_write(A_CTRL, 32'h1);
    ahb_read(A_CTRL, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL ctrl_readback: got %h expected 1", r); end
    ahb_write(A_SPARE, 32'hFFFF_FFFF);
    ahb_read(A_SPARE, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL spare_read: got %h expected 0", r); end
    ahb_read(A_DATA, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL data_read: got %h expected 0", r); end
    c0 = cyc;
    ahb_write(A_DATA, 32'h41);
    wait_frames(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_timeout: got %0d frames expected 1", rx_byte_q.size()); end
    // address edge, push edge, IDLE->START edge, then the registered line
    checks++; if (rx_start_q[0] - c0 != 5) begin errors++; $display("FAIL tx_latency: got %0d expected 5", rx_start_q[0] - c0); end
    checks++; if (rx_frame_q[0] !== {1'b1, 8'h41, 1'b0}) begin errors++; $display("FAIL frame_0x41: got %b expected %b", rx_frame_q[0], {1'b1, 8'h41, 1'b0}); end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL bit_timing: got %0d errors expected 0", frame_err); end
    repeat (4) @(posedge HCLK_I);
    #1;
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0001 || TXD_O !== 1'b1) begin errors++; $display("FAIL idle_after_frame: got %h/%b expected 00000001/1", r, TXD_O); end
    clear_rx();
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    ahb_write(A_CTRL, 32'h0);
    fill_fifo(DEPTH);
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0802) begin errors++; $display("FAIL full_status: got %h expected 00000802", r); end
    ahb_write(A_DATA, 32'hEE);
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0806) begin errors++; $display("FAIL ovf_status: got %h expected 00000806", r); end
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0802) begin errors++; $display("FAIL ovf_cleared: got %h expected 00000802", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      if (exp_q.size() == 0) begin
        ahb_write(A_CTRL, 32'h0);
        fill_fifo(DEPTH);
        ahb_read(A_STATUS, r);
        checks++; if (r !== 32'h0802) begin errors++; $display("FAIL refill_status: got %h expected 00000802", r); end
      end
      ahb_write(A_CTRL, 32'h1);
      wait_frames(DEPTH, DEPTH * 10 * D + 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout pass %0d: got %0d frames expected %0d", pass, rx_byte_q.size(), DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
        checks++; if (rx_byte_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_order pass %0d idx %0d: got %h expected %h", pass, i, rx_byte_q[i], exp_q[i]); end
      end
      for (int i = 1; i < DEPTH; i++) begin
        checks++; if (rx_start_q[i] - rx_start_q[i-1] != 10 * D) begin errors++; $display("FAIL b2b_gap pass %0d idx %0d: got %0d expected %0d", pass, i, rx_start_q[i] - rx_start_q[i-1], 10 * D); end
      end
      checks++; if (frame_err != 0) begin errors++; $display("FAIL b2b_timing pass %0d: got %0d errors expected 0", pass, frame_err); end
      repeat (4) @(posedge HCLK_I);
      #1;
      ahb_read(A_STATUS, r);
      checks++; if (r !== 32'h0001) begin errors++; $display("FAIL b2b_idle pass %0d: got %h expected 00000001", pass, r); end
      exp_q.delete();
      clear_rx();
    end
  endtask

  task automatic test_push_on_pop();
    logic [31:0] r;
    bit ok;
    ahb_write(A_CTRL, 32'h0);
    fill_fifo(DEPTH);
    // enable commits, then the dropped DATA write lands on the first pop edge
    bus_cycle(1'b1, 1'b1, A_CTRL, 32'h0, r);
    bus_cycle(1'b1, 1'b1, A_DATA, 32'h1, r);
    bus_cycle(1'b0, 1'b0, 12'd0, {24'd0, 8'($urandom)}, r);
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0704) begin errors++; $display("FAIL pop_push_status: got %h expected 00000704", r); end
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0700) begin errors++; $display("FAIL pop_push_ovf_clr: got %h expected 00000700", r); end
    wait_frames(DEPTH, DEPTH * 10 * D + 50, ok);
    checks++; if (!ok || rx_byte_q.size() != DEPTH) begin errors++; $display("FAIL pop_push_frames: got %0d expected %0d", rx_byte_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (rx_byte_q[i] !== exp_q[i]) begin errors++; $display("FAIL pop_push_data idx %0d: got %h expected %h", i, rx_byte_q[i], exp_q[i]); end
    end
    exp_q.delete();
    clear_rx();
  endtask

  task automatic test_enable_clear();
    logic [31:0] r;
    bit ok;
    ahb_write(A_CTRL, 32'h0);
    fill_fifo(3);
    ahb_write(A_CTRL, 32'h1);
    ahb_write(A_CTRL, 32'h0);
    checks++; if (TXD_O !== 1'b0) begin errors++; $display("FAIL disable_in_start: got %b expected 0", TXD_O); end
    wait_frames(1, 10 * D + 20, ok);
    checks++; if (!ok || rx_byte_q[0] !== exp_q[0]) begin errors++; $display("FAIL disable_frame: got %h expected %h", rx_byte_q[0], exp_q[0]); end
    repeat (60) @(posedge HCLK_I);
    #1;
    checks++; if (rx_start_q.size() != 1 || TXD_O !== 1'b1) begin errors++; $display("FAIL disable_hold: got %0d starts txd %b expected 1 starts txd 1", rx_start_q.size(), TXD_O); end
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0200) begin errors++; $display("FAIL disable_status: got %h expected 00000200", r); end
    ahb_write(A_DATA, 32'h5A);
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0300) begin errors++; $display("FAIL disable_push: got %h expected 00000300", r); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] r;
    logic [7:0] b;
    int c0;
    do_reset();
    ahb_write(A_CTRL, 32'h1);
    b = 8'($urandom) & 8'hFE;
    c0 = cyc;
    ahb_write(A_DATA, {24'd0, b});
    ahb_write(A_DATA, 32'($urandom));
    while (cyc < c0 + 10) @(negedge HCLK_I);
    #2;
    checks++; if (TXD_O !== 1'b0) begin errors++; $display("FAIL mid_data_bit0: got %b expected 0", TXD_O); end
    HRESET_I = 1'b1;
    #1;
    checks++; if (TXD_O !== 1'b1) begin errors++; $display("FAIL async_reset_txd: got %b expected 1", TXD_O); end
    repeat (2) @(posedge HCLK_I);
    #1;
    HRESET_I = 1'b0;
    clear_rx();
    ahb_read(A_STATUS, r);
    checks++; if (r !== 32'h0001) begin errors++; $display("FAIL mid_reset_status: got %h expected 00000001", r); end
    ahb_read(A_CTRL, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_reset_ctrl: got %h expected 0", r); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    bit ok;
    int n;
    do_reset();
    ahb_write(A_CTRL, 32'h1);
    for (int round = 0; round < 6; round++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        fill_fifo(1);
        repeat ($urandom_range(0, 10)) begin
          @(posedge HCLK_I); #1;
        end
      end
      wait_frames(exp_q.size(), 6 * 10 * D + 50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout round %0d: got %0d expected %0d", round, rx_byte_q.size(), exp_q.size()); end
      repeat (4) @(posedge HCLK_I);
      #1;
      ahb_read(A_STATUS, r);
      checks++; if (r !== 32'h0001) begin errors++; $display("FAIL rand_idle round %0d: got %h expected 00000001", round, r); end
    end
    checks++; if (rx_byte_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", rx_byte_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (rx_byte_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data idx %0d: got %h expected %h", i, rx_byte_q[i], exp_q[i]); end
    end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL rand_timing: got %0d errors expected 0", frame_err); end
  endtask

  initial begin
    ahb.HSEL_I   = 1'b0;
    ahb.HREADY_I = 1'b1;
    ahb.HWRITE_I = 1'b0;
    ahb.HSIZE_I  = 3'd2;
    ahb.HADDR_I  = 12'd0;
    ahb.HRDATA_I = 32'd0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_back_to_back();
    test_push_on_pop();
    test_enable_clear();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ahb_console_tx.md
AHB_CONSOLE_TX -- requirements
Module: ahb_console_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, HCLK_I cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of 2, 2..64).
REQ-003 SHALL have port HCLK_I, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port HRESET_I, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports HSEL_I (1), HREADY_I (1), HWRITE_I (1), HSIZE_I (3), HADDR_I (12), all inputs, the AHB-Lite address phase.
REQ-006 SHALL have port HRDATA_I, input, 32, the write data from the master in the data phase.
REQ-007 SHALL have port HWDATA_O, output, 32, the read data to the master in the data phase.
REQ-008 SHALL have ports HREADY_O and HRESP_O, outputs, 1 each.
REQ-009 SHALL have port TXD_O, output, 1, serial 8N1 line, idle high.

Function
REQ-010 SHALL tie HRESP_O to 0 and HREADY_O to 1, giving zero-wait-state transfers.
REQ-011 SHALL register, when HSEL_I & HREADY_I, the value adr = HADDR_I[4:2], a write flag (HWRITE_I) and a read flag (!HWRITE_I); otherwise both flags SHALL be cleared. The registered values act in the following (data) cycle.
REQ-012 Register map (adr_d):
- 0 DATA: write pushes HRDATA_I[7:0]; read returns 0.
- 1 STATUS: read-only.
- 2 CTRL: bit0 ENABLE, R/W.
- All other addresses: reads 0, writes ignored.
REQ-013 STATUS format:
- bit0 IDLE = FIFO empty and serializer in IDLE.
- bit1 FULL.
- bit2 OVF (sticky).
- bits[14:8] count (0..FIFO_DEPTH).
- Other bits 0.
REQ-014 HWDATA_O SHALL be combinational from adr_d and current state during a read data phase, and 0 otherwise.
REQ-015 A DATA write when the FIFO is full, evaluated before any same-cycle pop, SHALL be dropped and SHALL set OVF; FIFO contents SHALL be unchanged.
REQ-016 A STATUS read SHALL return the current OVF and then clear it. If a new overflow occurs in the same cycle, set SHALL win and OVF SHALL remain 1.
REQ-017 FIFO SHALL be circular: read/write pointers wrap modulo FIFO_DEPTH; count in log2(FIFO_DEPTH)+1 bits; a simultaneous push and pop when not full SHALL leave count unchanged.
REQ-018 Serializer FSM SHALL have states IDLE, START, DATA, STOP, with a bit counter (0..7) and a divider counter (0..CLK_DIV-1).
REQ-019 IDLE -> START SHALL occur when ENABLE = 1 and the FIFO is non-empty; the FIFO head SHALL be popped into the shift register in that same cycle.
REQ-020 START SHALL drive TXD_O = 0 for CLK_DIV cycles, then go to DATA.
REQ-021 DATA SHALL drive the shift register bit0 (LSB first) for CLK_DIV cycles per bit, shift right, and go to STOP after 8 bits.
REQ-022 STOP SHALL drive TXD_O = 1 for CLK_DIV cycles, then:
- go directly to START (with a pop) if ENABLE = 1 and the FIFO is non-empty;
- otherwise go to IDLE.
REQ-023 A frame SHALL be exactly 10*CLK_DIV cycles; back-to-back frames SHALL have no idle gap.
REQ-024 Clearing ENABLE mid-frame SHALL complete the current frame, then hold IDLE; the FIFO SHALL still accept pushes.
REQ-025 TXD_O SHALL be registered (glitch-free), with a first-edge latency of 1 cycle after the IDLE -> START transition.

Reset
REQ-026 While HRESET_I = 1, asynchronously:
- FIFO empty, pointers 0;
- OVF = 0, ENABLE = 0;
- FSM in IDLE, counters 0;
- TXD_O = 1, HWDATA_O = 0;
- address-phase flags cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with TXD_O = 1 and SHALL discard FIFO contents.
REQ-028 After reset release, the first AHB address phase SHALL be accepted on the next rising edge.

Verification
REQ-029 Write CTRL = 1, write DATA = 0x41 (CLK_DIV = 4) -> TXD_O pattern 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles, 40 cycles total; STATUS reads IDLE = 1 afterward.
REQ-030 With ENABLE = 0, write 8 bytes -> STATUS = 0x0802 (count 8, FULL); a 9th write -> OVF set, STATUS = 0x0806; the next STATUS read returns 0x0802.
REQ-031 Fill the FIFO with 8 bytes, set ENABLE -> 8 frames back-to-back with no idle gap; bytes emitted in write order; pointer wrap verified on a second fill of 8 bytes.
REQ-032 Push during the last pop cycle with FIFO full -> push dropped, OVF = 1, count = 7.
REQ-033 Assert HRESET_I during the DATA state of a frame -> TXD_O = 1 within the same cycle; STATUS = 0x0001 after release.
REQ-034 Clear ENABLE during START of frame 1 with 3 bytes queued -> frame 1 completes, TXD_O stays high, count = 2.
